dproc_out_buffer: RTL and testbench

DPROC_OUT_BUFFER -- requirements
Module: dproc_out_buffer

---
 rtl/dproc_out_buffer.sv | 137 +++++++++++++
 tb/tb_dproc_out_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dproc_out_buffer.sv
// Output pixel buffer: FIFO between the processing core and a CPU-visible register window.
// Each entry holds the pixel and an end-of-line flag derived from an internal column counter.
module dproc_out_buffer #(
  parameter int          DEPTH     = 16,
  parameter int          IMG_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0200_1100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        irq
);

  localparam int               PTR_W     = $clog2(DEPTH);
  localparam int               COL_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [6:0]       DEPTH_LVL = 7'(DEPTH);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_WIDTH - 1);

  typedef enum logic [2:0] {
    REG_NONE, REG_CONTROL, REG_STATUS, REG_LEVEL, REG_DATA, REG_LINES
  } reg_sel_e;

  logic [8:0]       fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [6:0]       level;
  logic [COL_W-1:0] column;
  logic [31:0]      line_count;
  logic             enable;
  logic [4:0]       threshold;
  logic             underrun;

  reg_sel_e   reg_sel;
  logic       empty, full, bus_wr, bus_rd, clear, data_rd, push, pop, eol_in;
  logic [8:0] head;
  logic       unused_wdata;

  assign unused_wdata = ^{mem_wdata[31:13], mem_wdata[7:4], mem_wdata[2]};

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    reg_sel = REG_NONE;
    if (mem_valid) begin
      if      (mem_addr == BASE_ADDR)            reg_sel = REG_CONTROL;
      else if (mem_addr == BASE_ADDR + 32'h04)   reg_sel = REG_STATUS;
      else if (mem_addr == BASE_ADDR + 32'h08)   reg_sel = REG_LEVEL;
      else if (mem_addr == BASE_ADDR + 32'h0C)   reg_sel = REG_DATA;
      else if (mem_addr == BASE_ADDR + 32'h10)   reg_sel = REG_LINES;
    end
  end

  assign mem_ready = (reg_sel != REG_NONE);
  assign bus_wr    = mem_ready && mem_wstrb[0];
  assign bus_rd    = mem_ready && (mem_wstrb == 4'h0);
  assign clear     = bus_wr && (reg_sel == REG_CONTROL) && mem_wdata[1];
  assign data_rd   = bus_rd && (reg_sel == REG_DATA);

  assign empty   = (level == 7'd0);
  assign full    = (level == DEPTH_LVL);
  assign s_ready = enable && !full;
  assign push    = s_valid && s_ready;
  assign pop     = data_rd && !empty;
  assign eol_in  = (column == COL_LAST);
  assign head    = fifo_mem[rd_ptr];

  always_comb begin
    mem_rdata = 32'h0;
    case (reg_sel)
      REG_CONTROL: mem_rdata = {19'h0, threshold, 7'h0, enable};
      REG_STATUS:  mem_rdata = {28'h0, underrun, irq, full, empty};
      REG_LEVEL:   mem_rdata = {25'h0, level};
      REG_DATA:    mem_rdata = empty ? 32'h0 : {22'h0, head[8], 1'b1, head[7:0]};
      REG_LINES:   mem_rdata = line_count;
      default:     mem_rdata = 32'h0;
    endcase
  end

  // NOTE: storage is deliberately not reset; resetting the pointers makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push && !clear) fifo_mem[wr_ptr] <= {eol_in, s_pixel};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      column     <= '0;
      line_count <= '0;
      enable     <= 1'b0;
      threshold  <= '0;
      underrun   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (bus_wr && reg_sel == REG_CONTROL) begin
        enable    <= mem_wdata[0];
        threshold <= mem_wdata[12:8];
      end
      irq <= enable && (threshold != 5'd0) && (level >= {2'b00, threshold});

      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        level      <= '0;
        column     <= '0;
        line_count <= '0;
        underrun   <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          column <= eol_in ? '0 : column + COL_W'(1);
          if (eol_in) line_count <= line_count + 32'd1;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   level <= level + 7'd1;
          2'b01:   level <= level - 7'd1;
          default: level <= level;
        endcase
        // A same-cycle empty read wins over a write-1-to-clear; the two cannot coincide on one bus anyway.
        if (data_rd && empty)
          underrun <= 1'b1;
        else if (bus_wr && reg_sel == REG_STATUS && mem_wdata[3])
          underrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dproc_out_buffer.sv
// Directed self-checking bench for dproc_out_buffer with default parameters.
module tb_dproc_out_buffer;

  localparam logic [31:0] BASE     = 32'h0200_1100;
  localparam logic [31:0] R_CTRL   = 32'h00;
  localparam logic [31:0] R_STATUS = 32'h04;
  localparam logic [31:0] R_LEVEL  = 32'h08;
  localparam logic [31:0] R_DATA   = 32'h0C;
  localparam logic [31:0] R_LINES  = 32'h10;

  logic        clk = 1'b0;
  logic        resetn;
  logic [7:0]  s_pixel;
  logic        s_valid;
  logic        s_ready;
  logic        mem_valid;
  logic        mem_ready;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  dproc_out_buffer #(.DEPTH(16), .IMG_WIDTH(32), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .s_pixel   (s_pixel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_wstrb (mem_wstrb),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_rd(input logic [31:0] off, output logic [31:0] data, output logic rdy);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_wstrb = 4'h0;
    mem_addr  = BASE + off;
    #1;
    data = mem_rdata;
    rdy  = mem_ready;
    @(posedge clk);
    #1 mem_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [31:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_rd(off, d, r);
    check(tag, d, exp);
  endtask

  task automatic bus_wr(input logic [31:0] off, input logic [31:0] data);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_wstrb = 4'hF;
    mem_addr  = BASE + off;
    mem_wdata = data;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic push(input logic [7:0] p);
    @(negedge clk);
    s_valid = 1'b1;
    s_pixel = p;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        r;
    logic [31:0] exp;

    resetn = 1'b0; s_valid = 1'b0; s_pixel = '0;
    mem_valid = 1'b0; mem_wstrb = '0; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", {31'h0, s_ready}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    rd_check("rst_ctrl", R_CTRL, 32'h0);
    rd_check("rst_status", R_STATUS, 32'h1);
    rd_check("rst_level", R_LEVEL, 32'h0);
    rd_check("rst_lines", R_LINES, 32'h0);
    bus_rd(32'h14, d, r);
    check("unmapped_ready", {31'h0, r}, 32'h0);
    check("unmapped_data", d, 32'h0);

    // Basic push / drain / underrun
    bus_wr(R_CTRL, 32'h1);
    push(8'h11); push(8'h22); push(8'h33);
    bus_rd(R_LEVEL, d, r);
    check("lvl3_ready", {31'h0, r}, 32'h1);
    check("lvl3", d, 32'h3);
    rd_check("pop0", R_DATA, 32'h111);
    rd_check("pop1", R_DATA, 32'h122);
    rd_check("pop2", R_DATA, 32'h133);
    rd_check("pop_empty", R_DATA, 32'h000);
    rd_check("underrun", R_STATUS, 32'h9);
    bus_wr(R_STATUS, 32'h8);
    rd_check("underrun_w1c", R_STATUS, 32'h1);

    // Line framing: column restarts at 0 after the clear
    bus_wr(R_CTRL, 32'h3);
    rd_check("ctrl_clear_reads0", R_CTRL, 32'h1);
    for (int i = 0; i < 64; i++) begin
      push(8'(i));
      exp = {22'h0, (i % 32 == 31), 1'b1, 8'(i)};
      rd_check($sformatf("eol_px%0d", i + 1), R_DATA, exp);
    end
    rd_check("lines2", R_LINES, 32'h2);

    // Clear overrides a concurrent push
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
    rd_check("lvl5", R_LEVEL, 32'h5);
    @(negedge clk);
    s_valid = 1'b1; s_pixel = 8'h77;
    mem_valid = 1'b1; mem_wstrb = 4'hF; mem_addr = BASE + R_CTRL; mem_wdata = 32'h3;
    @(posedge clk);
    #1;
    s_valid = 1'b0; mem_valid = 1'b0; mem_wstrb = 4'h0;
    rd_check("clr_level", R_LEVEL, 32'h0);
    rd_check("clr_lines", R_LINES, 32'h0);
    rd_check("clr_ctrl", R_CTRL, 32'h1);
    rd_check("clr_no_store", R_DATA, 32'h0);
    bus_wr(R_STATUS, 32'h8);

    // Full and back-pressure
    bus_wr(R_CTRL, 32'h3);
    for (int i = 0; i < 16; i++) push(8'hA0 + 8'(i));
    rd_check("full_status", R_STATUS, 32'h2);
    @(negedge clk);
    s_valid = 1'b1; s_pixel = 8'hEE;
    #1 check("full_s_ready", {31'h0, s_ready}, 32'h0);
    bus_rd(R_DATA, d, r);
    check("full_pop", d, 32'h1A0);
    check("s_ready_after_pop", {31'h0, s_ready}, 32'h1);
    @(posedge clk);
    #1 s_valid = 1'b0;
    rd_check("held_accepted_lvl", R_LEVEL, 32'h10);
    for (int i = 1; i < 16; i++) rd_check($sformatf("drain%0d", i), R_DATA, 32'h1A0 + 32'(i));
    rd_check("drain_held", R_DATA, 32'h1EE);

    // Level threshold interrupt
    bus_wr(R_CTRL, 32'h0401);
    push(8'h41); push(8'h42); push(8'h43);
    @(posedge clk);
    #1 check("irq_lvl3", {31'h0, irq}, 32'h0);
    push(8'h44);
    check("irq_latency", {31'h0, irq}, 32'h0);
    @(posedge clk);
    #1 check("irq_set", {31'h0, irq}, 32'h1);
    rd_check("irq_status", R_STATUS, 32'h4);
    rd_check("irq_pop", R_DATA, 32'h141);
    check("irq_hold", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #1 check("irq_drop", {31'h0, irq}, 32'h0);

    // Simultaneous push and pop while non-empty
    @(negedge clk);
    s_valid = 1'b1; s_pixel = 8'h55;
    mem_valid = 1'b1; mem_wstrb = 4'h0; mem_addr = BASE + R_DATA;
    #1 check("simul_data", mem_rdata, 32'h142);
    @(posedge clk);
    #1;
    s_valid = 1'b0; mem_valid = 1'b0;
    rd_check("simul_level", R_LEVEL, 32'h3);

    // Disabled buffer still drains but refuses input
    for (int i = 0; i < 5; i++) push(8'h61 + 8'(i));
    rd_check("lvl8", R_LEVEL, 32'h8);
    bus_wr(R_CTRL, 32'h0);
    check("dis_s_ready", {31'h0, s_ready}, 32'h0);
    rd_check("dis_pop", R_DATA, 32'h143);
    push(8'h99);
    rd_check("dis_level", R_LEVEL, 32'h7);
    bus_wr(R_CTRL, 32'h0101);
    push(8'h66);
    @(posedge clk);
    #1 check("pre_rst_irq", {31'h0, irq}, 32'h1);

    // Reset with eight entries buffered
    @(negedge clk) resetn = 1'b0;
    @(posedge clk);
    #1;
    check("rst2_s_ready", {31'h0, s_ready}, 32'h0);
    check("rst2_irq", {31'h0, irq}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    rd_check("rst2_ctrl", R_CTRL, 32'h0);
    rd_check("rst2_status", R_STATUS, 32'h1);
    rd_check("rst2_level", R_LEVEL, 32'h0);
    rd_check("rst2_lines", R_LINES, 32'h0);
    rd_check("rst2_data", R_DATA, 32'h0);

    // Simultaneous push and pop while empty
    bus_wr(R_CTRL, 32'h3);
    @(negedge clk);
    s_valid = 1'b1; s_pixel = 8'h99;
    mem_valid = 1'b1; mem_wstrb = 4'h0; mem_addr = BASE + R_DATA;
    #1 check("simul_empty_data", mem_rdata, 32'h0);
    @(posedge clk);
    #1;
    s_valid = 1'b0; mem_valid = 1'b0;
    rd_check("simul_empty_level", R_LEVEL, 32'h1);
    rd_check("simul_empty_status", R_STATUS, 32'h8);
    rd_check("simul_empty_pop", R_DATA, 32'h199);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
